// File: rtl/mem_1r1w_arb_pkg.sv
// Shared definitions for the 1R1W memory arbiter.
// Default geometry, FSM states and the round-robin pick function.
package mem_1r1w_arb_pkg;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREQ   = 2;
  localparam int DEF_ID_W   = 1;

  // Widest requester count the pick function handles.
  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // One-hot grant: first valid index at or after ptr, modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input logic [PTR_W:0]     n
  );
    logic [MAX_REQ-1:0] g;
    logic [PTR_W:0]     idx;
    logic               found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= n) idx = idx - n;
      if (((PTR_W+1)'(k) < n) && !found
          && valid[idx[PTR_W-1:0]]) begin
        g[idx[PTR_W-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one memory port.
// Grant is combinational from valid and ptr; next_ptr follows the grant.
module rr_arbiter
  import mem_1r1w_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = DEF_ID_W
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o,
  output logic [ID_W-1:0] next_ptr_o
);

  logic [MAX_REQ-1:0] pick;
  logic [PTR_W:0]     id;
  logic [PTR_W:0]     nxt;

  assign pick = rr_pick(MAX_REQ'(valid_i),
                        PTR_W'(ptr_i),
                        (PTR_W+1)'(NREQ));

  // Encode the one-hot pick into an index.
  always_comb begin
    id = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) id = (PTR_W+1)'(i);
    end
  end

  assign any_o    = |pick;
  assign grant_o  = NREQ'(pick);
  assign gnt_id_o = ID_W'(id);

  assign nxt = (id == (PTR_W+1)'(NREQ-1))
             ? '0 : id + 1'b1;

  assign next_ptr_o = any_o ? ID_W'(nxt) : ptr_i;

endmodule

// File: rtl/mem_1r1w_arbiter.sv
// Shares one 1R1W SRAM between NREQ readers and NREQ writers.
// Optional zero-fill after reset: define MEM_ARB_INIT_EN.
module mem_1r1w_arbiter
  import mem_1r1w_arb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREQ   = DEF_NREQ,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        rd_req_valid,
  output logic [NREQ-1:0]        rd_req_ready,
  input  logic [NREQ*ADDR_W-1:0] rd_req_addr,
  input  logic [NREQ-1:0]        wr_req_valid,
  output logic [NREQ-1:0]        wr_req_ready,
  input  logic [NREQ*ADDR_W-1:0] wr_req_addr,
  input  logic [NREQ*WIDTH-1:0]  wr_req_data,
  output logic                   rd_resp_valid,
  output logic [ID_W-1:0]        rd_resp_id,
  output logic [WIDTH-1:0]       rd_resp_data,
  output logic                   init_done,
  output logic [ADDR_W-1:0]      mem_R0_addr,
  output logic                   mem_R0_en,
  input  logic [WIDTH-1:0]       mem_R0_data,
  output logic [ADDR_W-1:0]      mem_W0_addr,
  output logic                   mem_W0_en,
  output logic [WIDTH-1:0]       mem_W0_data
);

  if (DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
    $error("DEPTH exceeds address range");
  end

  state_e              state_q;
  logic                run;
  logic                init_wr;
  logic [ADDR_W-1:0]   init_addr;

  logic [NREQ-1:0]     rd_gnt;
  logic [NREQ-1:0]     wr_gnt;
  logic                rd_any;
  logic                wr_any;
  logic [ID_W-1:0]     rd_id;
  logic [ID_W-1:0]     wr_id;
  logic [ID_W-1:0]     rd_ptr_q;
  logic [ID_W-1:0]     rd_ptr_d;
  logic [ID_W-1:0]     wr_ptr_q;
  logic [ID_W-1:0]     wr_ptr_d;

  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                collide;

  logic                resp_valid_q;
  logic [ID_W-1:0]     resp_id_q;
  logic                coll_q;
  logic [WIDTH-1:0]    byp_q;

`ifdef MEM_ARB_INIT_EN
  logic [ADDR_W-1:0]   cnt_q;

  // Zero-fill sweep, one address per cycle, then RUN forever.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(DEPTH-1)) state_q <= RUN;
        end
        default: ;
      endcase
    end
  end

  assign init_wr   = (state_q == INIT) & ~reset;
  assign init_addr = cnt_q;
`else
  assign state_q   = RUN;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign run       = (state_q == RUN) & ~reset;
  assign init_done = run;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rd_arb (
    .valid_i    (rd_req_valid & {NREQ{run}}),
    .ptr_i      (rd_ptr_q),
    .grant_o    (rd_gnt),
    .gnt_id_o   (rd_id),
    .any_o      (rd_any),
    .next_ptr_o (rd_ptr_d)
  );

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_wr_arb (
    .valid_i    (wr_req_valid & {NREQ{run}}),
    .ptr_i      (wr_ptr_q),
    .grant_o    (wr_gnt),
    .gnt_id_o   (wr_id),
    .any_o      (wr_any),
    .next_ptr_o (wr_ptr_d)
  );

  // Route the granted requester's fields to the memory ports.
  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_any && rd_id == ID_W'(i))
        rd_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
      if (wr_any && wr_id == ID_W'(i)) begin
        wr_addr = wr_req_addr[i*ADDR_W +: ADDR_W];
        wr_data = wr_req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign collide = rd_any & wr_any & (rd_addr == wr_addr);

  // Round-robin pointers advance past each grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Track the in-flight read and capture write data on collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      coll_q       <= 1'b0;
      byp_q        <= '0;
    end else begin
      resp_valid_q <= rd_any;
      coll_q       <= collide;
      if (rd_any) resp_id_q <= rd_id;
      if (collide) byp_q <= wr_data;
    end
  end

  assign rd_req_ready = rd_gnt;
  assign wr_req_ready = wr_gnt;

  assign mem_R0_en   = rd_any;
  assign mem_R0_addr = rd_addr;

  assign mem_W0_en   = wr_any | init_wr;
  assign mem_W0_addr = init_wr ? init_addr : wr_addr;
  assign mem_W0_data = init_wr ? '0 : wr_data;

  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_id    = resp_id_q;
  assign rd_resp_data  = !resp_valid_q ? '0
                       : coll_q ? byp_q : mem_R0_data;

endmodule

// File: tb/tb_mem_1r1w_arbiter.sv
// Testbench for mem_1r1w_arbiter with a behavioural SRAM.
// Directed stimulus; read responses checked through a scoreboard.
module tb_mem_1r1w_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   rd_req_valid;
  logic [1:0]   rd_req_ready;
  logic [9:0]   rd_req_addr;
  logic [1:0]   wr_req_valid;
  logic [1:0]   wr_req_ready;
  logic [9:0]   wr_req_addr;
  logic [127:0] wr_req_data;
  logic         rd_resp_valid;
  logic         rd_resp_id;
  logic [63:0]  rd_resp_data;
  logic         init_done;
  logic [4:0]   mem_R0_addr;
  logic         mem_R0_en;
  logic [63:0]  mem_R0_data = '0;
  logic [4:0]   mem_W0_addr;
  logic         mem_W0_en;
  logic [63:0]  mem_W0_data;

  typedef struct {
    int          due;
    logic        id;
    logic [63:0] data;
  } exp_t;

  exp_t  q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  logic [63:0] mem [32];
  logic [31:0] wr_seen = '0;

  localparam logic [63:0] D31 = 64'h3131_0000_0000_001F;
  localparam logic [63:0] D0  = 64'h0000_0000_0000_0A0A;
  localparam logic [63:0] DA  = 64'h0000_0000_0000_3333;
  localparam logic [63:0] DB  = 64'h0000_0000_0000_7777;
  localparam logic [63:0] DC  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D9  = 64'h0000_0000_0000_9999;

  mem_1r1w_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_id    (rd_resp_id),
    .rd_resp_data  (rd_resp_data),
    .init_done     (init_done),
    .mem_R0_addr   (mem_R0_addr),
    .mem_R0_en     (mem_R0_en),
    .mem_R0_data   (mem_R0_data),
    .mem_W0_addr   (mem_W0_addr),
    .mem_W0_en     (mem_W0_en),
    .mem_W0_data   (mem_W0_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Unwritten words read back as a recognisable nonzero pattern.
  always @(posedge clock) begin
    if (mem_R0_en)
      mem_R0_data <= wr_seen[mem_R0_addr] ? mem[mem_R0_addr]
                   : (64'hC0DE_0000_0000_0000 | 64'(mem_R0_addr));
    if (mem_W0_en) begin
      mem[mem_W0_addr]     <= mem_W0_data;
      wr_seen[mem_W0_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard when a response is due.
  always @(negedge clock) begin : mon
    logic ev;
    exp_t e;
    if (!reset) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("resp_valid", 64'(rd_resp_valid), 64'(ev));
      if (ev) begin
        e = q.pop_front();
        if (rd_resp_valid) begin
          chk("resp_id", 64'(rd_resp_id), 64'(e.id));
          chk("resp_data", rd_resp_data, e.data);
        end
      end
    end
  end

  task automatic rst_check();
    chk("rst_rd_ready", 64'(rd_req_ready), 0);
    chk("rst_wr_ready", 64'(wr_req_ready), 0);
    chk("rst_resp_valid", 64'(rd_resp_valid), 0);
    chk("rst_resp_id", 64'(rd_resp_id), 0);
    chk("rst_resp_data", rd_resp_data, 0);
    chk("rst_init_done", 64'(init_done), 0);
    chk("rst_R0_en", 64'(mem_R0_en), 0);
    chk("rst_R0_addr", 64'(mem_R0_addr), 0);
    chk("rst_W0_en", 64'(mem_W0_en), 0);
    chk("rst_W0_addr", 64'(mem_W0_addr), 0);
    chk("rst_W0_data", mem_W0_data, 0);
  endtask

  task automatic step(input logic [1:0]  rv,
                      input logic [4:0]  ra0,
                      input logic [4:0]  ra1,
                      input logic [1:0]  wv,
                      input logic [4:0]  wa0,
                      input logic [4:0]  wa1,
                      input logic [63:0] wd0,
                      input logic [63:0] wd1,
                      input logic [1:0]  er,
                      input logic [1:0]  ew,
                      input logic [63:0] erd);
    logic [4:0]  era;
    logic [4:0]  ewa;
    logic [63:0] ewd;
    rd_req_valid = rv;
    rd_req_addr  = {ra1, ra0};
    wr_req_valid = wv;
    wr_req_addr  = {wa1, wa0};
    wr_req_data  = {wd1, wd0};
    era = er[1] ? ra1 : (er[0] ? ra0 : 5'd0);
    ewa = ew[1] ? wa1 : (ew[0] ? wa0 : 5'd0);
    ewd = ew[1] ? wd1 : (ew[0] ? wd0 : 64'd0);
    #1;
    chk("rd_ready", 64'(rd_req_ready), 64'(er));
    chk("wr_ready", 64'(wr_req_ready), 64'(ew));
    chk("init_done", 64'(init_done), 1);
    chk("R0_en", 64'(mem_R0_en), 64'(|er));
    chk("R0_addr", 64'(mem_R0_addr), 64'(era));
    chk("W0_en", 64'(mem_W0_en), 64'(|ew));
    chk("W0_addr", 64'(mem_W0_addr), 64'(ewa));
    chk("W0_data", mem_W0_data, ewd);
    if (er != 2'b00)
      q.push_back('{due: cyc + 1, id: er[1], data: erd});
    @(negedge clock);
  endtask

  task automatic idle();
    step(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endtask

`ifdef MEM_ARB_INIT_EN
  task automatic init_cycle(input int c);
    rd_req_valid = 2'b11;
    wr_req_valid = 2'b11;
    #1;
    chk("init_W0_en", 64'(mem_W0_en), 1);
    chk("init_W0_addr", 64'(mem_W0_addr), 64'(c));
    chk("init_W0_data", mem_W0_data, 0);
    chk("init_rd_ready", 64'(rd_req_ready), 0);
    chk("init_wr_ready", 64'(wr_req_ready), 0);
    chk("init_done_low", 64'(init_done), 0);
    chk("init_R0_en", 64'(mem_R0_en), 0);
    @(negedge clock);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rd_req_valid = 2'b11;
    wr_req_valid = 2'b11;
    rd_req_addr  = 10'h3FF;
    wr_req_addr  = 10'h3FF;
    wr_req_data  = {2{64'hFFFF_FFFF_FFFF_FFFF}};
    repeat (2) @(negedge clock);
    rst_check();
    reset = 1'b0;

`ifdef MEM_ARB_INIT_EN
    for (int c = 0; c < 10; c++) init_cycle(c);
    rd_req_valid = 2'b11;
    wr_req_valid = 2'b11;
    #1;
    chk("pre_rst_W0_addr", 64'(mem_W0_addr), 10);
    reset = 1'b1;
    #1;
    rst_check();
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 32; c++) init_cycle(c);
    // Zero-filled word reads back as 0.
    step(2'b10, 0, 12, 2'b00, 0, 0, 0, 0,
         2'b10, 2'b00, 64'h0);
`else
    // Granted on the very first cycle after release.
    step(2'b10, 0, 4, 2'b00, 0, 0, 0, 0,
         2'b10, 2'b00, 64'hC0DE_0000_0000_0004);
`endif

    // Lone writers: 1 at addr 31, then 0 at addr 0.
    step(2'b00, 0, 0, 2'b10, 0, 31, 0, D31,
         2'b00, 2'b10, 0);
    step(2'b00, 0, 0, 2'b01, 0, 0, D0, 0,
         2'b00, 2'b01, 0);
    // Both writers: ptr=1 grants 1 first, then 0.
    step(2'b00, 0, 0, 2'b11, 3, 7, DA, DB,
         2'b00, 2'b10, 0);
    step(2'b00, 0, 0, 2'b11, 3, 7, DA, DB,
         2'b00, 2'b01, 0);
    // Both readers: strict alternation from ptr=0.
    step(2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, DA);
    step(2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, DB);
    step(2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, DA);
    step(2'b11, 3, 7, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, DB);
    // Same-address read and write: new data bypassed.
    step(2'b01, 5, 0, 2'b01, 5, 0, DC, 0, 2'b01, 2'b01, DC);
    step(2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, DC);
    // Read ptr=1: requester 1 first, then 0.
    step(2'b11, 0, 31, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, D31);
    step(2'b01, 0, 31, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, D0);
    // Read and write to different addresses.
    step(2'b01, 3, 0, 2'b10, 0, 9, 0, D9, 2'b01, 2'b10, DA);
    idle();
    step(2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, D9);
    idle();
    idle();

    chk("sb_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
